// File: rtl/mem_responder_pkg.sv
// Shared widths, default depth and FSM state encoding for the memory responder.
package mem_responder_pkg;

    localparam int MRSP_ADDR_WIDTH = 32;
    localparam int MRSP_DATA_WIDTH = 32;
    localparam int MRSP_MEM_DEPTH  = 64;

    typedef enum logic [1:0] {
        MRSP_IDLE = 2'd0,
        MRSP_WAIT = 2'd1,
        MRSP_RESP = 2'd2
    } mrsp_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake between the core-side initiator and the memory responder.
// The bidirectional Data bus stays a plain inout port on the responder.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = MRSP_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] Addr;
    logic                  we;
    logic                  req_valid;
    logic                  data_valid;
    logic                  busy;

    modport master (
        output Addr,
        output we,
        output req_valid,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  Addr,
        input  we,
        input  req_valid,
        output data_valid,
        output busy
    );
endinterface

// File: rtl/mem_responder_array.sv
// Synchronous word array: one access port (read or write) plus a backdoor write port.
// A backdoor write to the same word as a bus write on the same edge takes precedence;
// a read on the same edge as a backdoor write returns the old contents.
module mem_array_1rw1w #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             acc_en,
    input  logic             acc_we,
    input  logic [IDX_W-1:0] acc_idx,
    input  logic [WIDTH-1:0] acc_wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [WIDTH-1:0] load_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Read data is captured only on a read access edge and held otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (acc_en && !acc_we) begin
            rdata_d = mem[acc_idx];
        end
    end

    // Array writes: the backdoor assignment comes last so it wins on a same-word collision.
    always_ff @(posedge clk) begin
        if (acc_en && acc_we) begin
            mem[acc_idx] <= acc_wdata;
        end
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    // Read data register; contents are not reset, like the array itself.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, returns read data or a
// write acknowledge after READ_LATENCY edges, and drives Data only in its read-response cycle.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH    = MRSP_MEM_DEPTH,
    parameter int DATA_WIDTH   = MRSP_DATA_WIDTH,
    parameter int ADDR_WIDTH   = MRSP_ADDR_WIDTH,
    parameter int READ_LATENCY = 2,
    parameter int IDX_W        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    inout  wire [DATA_WIDTH-1:0]  Data,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);
    localparam int CNT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

    mrsp_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  data_valid_q, data_valid_d;
    logic                  busy_q, busy_d;
    logic                  acc_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic [IDX_W-1:0]      req_idx;
    logic                  addr_unused;

    // Word index from the byte address; byte offset and upper bits alias away.
    assign req_idx     = bus.Addr[IDX_W+1:2];
    assign addr_unused = ^{bus.Addr[ADDR_WIDTH-1:IDX_W+2], bus.Addr[1:0]};

    // Next-state logic for the request FSM, latency counter and captured request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            MRSP_IDLE: begin
                if (bus.req_valid) begin
                    idx_d   = req_idx;
                    we_d    = bus.we;
                    wdata_d = bus.we ? Data : wdata_q;
                    if (READ_LATENCY == 1) begin
                        state_d = MRSP_RESP;
                    end else begin
                        state_d = MRSP_WAIT;
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                    end
                end
            end
            MRSP_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MRSP_RESP;
                end
            end
            MRSP_RESP: begin
                state_d = MRSP_IDLE;
            end
            default: begin
                state_d = MRSP_IDLE;
            end
        endcase
        data_valid_d = (state_d == MRSP_RESP);
        busy_d       = (state_d != MRSP_IDLE);
    end

    // The access happens on the edge entering RESP; outside IDLE the _d request
    // fields equal the held _q values, and from IDLE they are the live capture.
    assign acc_en = (state_d == MRSP_RESP) && (state_q != MRSP_RESP);

    // FSM and registered outputs; reset drops any request not yet at its access edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= MRSP_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    mem_array_1rw1w #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk       (clk),
        .acc_en    (acc_en),
        .acc_we    (we_d),
        .acc_idx   (idx_d),
        .acc_wdata (wdata_d),
        .rdata     (rdata),
        .load_en   (load_en),
        .load_idx  (load_addr),
        .load_data (load_data)
    );

    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;

    // Sole driver of the shared Data bus: read-response cycle only.
    assign Data = (state_q == MRSP_RESP && !we_q) ? rdata : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard queue of expected responses.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int RL = 2;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_data = '0;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    wire  [31:0] Data;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    assign Data = tb_drv ? tb_data : {32{1'bz}};

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_WIDTH(32)) bus ();

    mem_responder #(
        .MEM_DEPTH    (64),
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .READ_LATENCY (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .Data      (Data),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    function automatic logic data_released(input logic [31:0] d);
        return $isunknown(d) || (d == 32'h0);
    endfunction

    // Monitor: pops the scoreboard on every response, checks reset state and bus release.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || !data_released(Data)) begin
                    failures++;
                    $display("FAIL reset_state dv=%b busy=%b data=%h required dv=0 busy=0 data=Z",
                             bus.data_valid, bus.busy, Data);
                end
            end else if (bus.data_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp data=%h with empty scoreboard", Data);
                end else begin
                    mon_e = sb.pop_front();
                    if (Data !== mon_e.data) begin
                        failures++;
                        $display("FAIL %s got=%h required=%h",
                                 mon_e.is_rd ? "read_data" : "write_ack_data", Data, mon_e.data);
                    end
                end
            end else if (!tb_drv) begin
                checks++;
                if (!data_released(Data)) begin
                    failures++;
                    $display("FAIL data_not_z got=%h required=Z", Data);
                end
            end
        end
    end

    task automatic backdoor(input logic [5:0] idx, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = idx;
        load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // Issue one request, check latency and busy; optionally fire a backdoor load on the access edge.
    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] d,
                          input logic coll, input logic [5:0] cidx, input logic [31:0] cdata);
        int  n;
        logic seen;
        sb.push_back('{is_rd: !wr, data: d});
        bus.Addr = addr;
        bus.we = wr;
        bus.req_valid = 1'b1;
        tb_drv = wr;
        tb_data = wr ? d : 32'h0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (coll) begin
                load_en = (n == RL - 1);
                load_addr = cidx;
                load_data = cdata;
            end
            @(negedge clk);
            if (bus.data_valid) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_wait got=%b required=1 at edge %0d", bus.busy, n);
                end
            end
        end
        checks++;
        if (!seen || n != RL) begin
            failures++;
            $display("FAIL latency seen=%b edges=%0d required=%0d", seen, n, RL);
        end
        load_en = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.we = 1'b0;
        tb_drv = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_idle got=%b required=0", bus.busy);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [8:0] dv_pat;
        logic [8:0] busy_pat;
        bus.Addr = '0;
        bus.we = 1'b0;
        bus.req_valid = 1'b0;
        #1 reset = 1'b0;
        // Preload while in reset: the backdoor works in any state.
        repeat (2) @(negedge clk);
        #1;
        backdoor(6'd3, 32'hDEADBEEF);
        backdoor(6'd2, 32'h00000000);
        @(negedge clk);
        reset = 1'b1;
        #1;

        do_req(32'h0000000C, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0);
        do_req(32'h00000010, 1'b1, 32'h12345678, 1'b0, 6'd0, 32'h0);
        do_req(32'h00000010, 1'b0, 32'h12345678, 1'b0, 6'd0, 32'h0);
        do_req(32'h0000010E, 1'b0, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0);

        // Held request: responses after edges 2, 5, 8; IDLE after edges 3, 6, 9.
        dv_pat   = 9'b010010010;
        busy_pat = 9'b011011011;
        repeat (3) sb.push_back('{is_rd: 1'b1, data: 32'hDEADBEEF});
        bus.Addr = 32'h0000000C;
        bus.we = 1'b0;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.data_valid !== dv_pat[k] || bus.busy !== busy_pat[k]) begin
                failures++;
                $display("FAIL held_req edge=%0d dv=%b busy=%b required dv=%b busy=%b",
                         k + 1, bus.data_valid, bus.busy, dv_pat[k], busy_pat[k]);
            end
        end
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;

        // Backdoor load wins over a same-edge bus write to the same word.
        do_req(32'h00000014, 1'b1, 32'h00000001, 1'b1, 6'd5, 32'hAAAA5555);
        do_req(32'h00000014, 1'b0, 32'hAAAA5555, 1'b0, 6'd0, 32'h0);
        // A read on the same edge as a backdoor load returns the old word.
        do_req(32'h0000000C, 1'b0, 32'hDEADBEEF, 1'b1, 6'd3, 32'h11111111);
        do_req(32'h0000000C, 1'b0, 32'h11111111, 1'b0, 6'd0, 32'h0);
        do_req(32'h00000020, 1'b1, 32'hCAFEF00D, 1'b0, 6'd0, 32'h0);
        do_req(32'h00000020, 1'b0, 32'hCAFEF00D, 1'b0, 6'd0, 32'h0);

        // Reset during WAIT drops the pending write to index 2.
        bus.Addr = 32'h00000008;
        bus.we = 1'b1;
        tb_drv = 1'b1;
        tb_data = 32'hFFFFFFFF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.we = 1'b0;
        tb_drv = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        do_req(32'h00000008, 1'b0, 32'h00000000, 1'b0, 6'd0, 32'h0);
        do_req(32'h00000010, 1'b0, 32'h12345678, 1'b0, 6'd0, 32'h0);

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
